// File: rtl/conv_addr_pkg.sv
// conv_addr_pkg: shared types for the sliding-window address generator.
//   state_e     : controller states (IDLE, RUN, DONE)
//   cfg_t       : latched layer configuration
//   beat_count  : number of beats a configuration produces (0 when illegal)
package conv_addr_pkg;

  localparam int CA_DIM_W  = 9;
  localparam int CA_CH_W   = 4;
  localparam int CA_ADDR_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CA_DIM_W-1:0] img_w;
    logic [CA_DIM_W-1:0] img_h;
    logic [CA_DIM_W-1:0] ker_w;
    logic [CA_DIM_W-1:0] ker_h;
    logic [CA_DIM_W-1:0] stride;
    logic [CA_CH_W-1:0]  num_ch;
    logic [1:0]          pad;
  } cfg_t;

  function automatic int unsigned beat_count(cfg_t c);
    int unsigned ew, eh, kw, kh, s, ch;
    ew = 32'(c.img_w) + 32'(c.pad) * 2;
    eh = 32'(c.img_h) + 32'(c.pad) * 2;
    kw = 32'(c.ker_w);
    kh = 32'(c.ker_h);
    s  = 32'(c.stride);
    ch = 32'(c.num_ch);
    if (c.img_w == '0 || c.img_h == '0 || kw == 0 || kh == 0 || s == 0 || ch == 0 ||
        kw > ew || kh > eh)
      return 0;
    return ch * kw * kh * ((ew - kw) / s + 1) * ((eh - kh) / s + 1);
  endfunction

endpackage

// File: rtl/conv_addr_cnt.sv
// conv_addr_cnt: one loop level of the window sweep.
//   clk, reset : clock, async active-high reset
//   clr        : force the count back to 0 (run start)
//   en         : advance by step this cycle
//   step/limit : increment and largest legal value
//   nxt        : value the counter takes at the next edge
//   at_last    : current value is the final one (another step would pass limit)
//   wrap       : advancing from the final value back to 0 this cycle
module conv_addr_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  output logic [W-1:0] nxt,
  output logic         at_last,
  output logic         wrap
);

  logic [W-1:0] cnt;
  logic [W:0]   sum;

  // one extra bit so cnt+step cannot alias past limit
  assign sum     = {1'b0, cnt} + {1'b0, step};
  assign at_last = sum > {1'b0, limit};
  assign wrap    = en & at_last;

  always_comb begin
    nxt = cnt;
    if (clr)     nxt = '0;
    else if (en) nxt = at_last ? '0 : sum[W-1:0];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else        cnt <= nxt;

endmodule

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: sliding-window read-address generator for the conv engine.
// Sweeps a KH x KW window over a W x H image (C channel planes at ch*W*H),
// origin stepping by S, emitting one linear address per accepted beat.
// Loop order, innermost first: kx, ky, ch, ox, oy.
// Ports:
//   clk, reset        clock, async active-high reset
//   start             pulse, latches cfg_* when idle
//   cfg_*             image/kernel dims, stride, channel count (cfg_pad: pad width)
//   addr/addr_valid/addr_ready  beat handshake; beat held until accepted
//   addr_pad          beat lies in zero padding, addr forced to 0
//   win_last          last beat of the current window
//   busy              run in progress (through the done cycle)
//   conv_done         one-cycle pulse after the final accept
//   cfg_err           sticky until next start: illegal configuration seen
// Build option: define CONV_ADDR_PAD_EN to add cfg_pad/addr_pad and zero padding;
// without it the pad width is fixed at 0 and all coordinates are unsigned.
module conv_addr_gen
  import conv_addr_pkg::*;
#(
  parameter int DIM_W  = CA_DIM_W,
  parameter int CH_W   = CA_CH_W,
  parameter int ADDR_W = CA_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_img_w,
  input  logic [DIM_W-1:0]  cfg_img_h,
  input  logic [DIM_W-1:0]  cfg_ker_w,
  input  logic [DIM_W-1:0]  cfg_ker_h,
  input  logic [DIM_W-1:0]  cfg_stride,
  input  logic [CH_W-1:0]   cfg_num_ch,
`ifdef CONV_ADDR_PAD_EN
  input  logic [1:0]        cfg_pad,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
`ifdef CONV_ADDR_PAD_EN
  output logic              addr_pad,
`endif
  output logic              win_last,
  output logic              busy,
  output logic              conv_done,
  output logic              cfg_err
);

  localparam int CW = DIM_W + 1;            // counter width (origin can reach W+2P-KW)
  localparam int EW = DIM_W + 2;            // W+2P
  localparam int FW = CH_W + 2*DIM_W + 2;   // full-width address before truncation
  localparam int NL = 5;                    // kx, ky, ch, ox, oy

  state_e state, state_n;
  cfg_t   cfg_in, cfg_q;
  logic [1:0] pad_in;
  logic [EW-1:0] ext_w_in, ext_h_in, ext_w_q, ext_h_q;
  logic legal_in, start_ok, load, fire, fin;

  logic [NL-1:0][CW-1:0] step, lim, nxt;
  logic [NL-1:0]         en, at_last, wrap;

  logic [DIM_W-1:0] w_n, h_n, kw_n, kh_n;
  logic [CH_W-1:0]  c_n;
  logic [FW-1:0]    a_full;
  logic             wl_n;

`ifdef CONV_ADDR_PAD_EN
  localparam int SW = DIM_W + 3;
  logic [1:0]          p_n;
  logic signed [SW-1:0] xs, ys;
  logic                pad_n;
  assign pad_in = cfg_pad;
`else
  assign pad_in = 2'd0;
`endif

  always_comb begin
    cfg_in        = '0;
    cfg_in.img_w  = cfg_img_w;
    cfg_in.img_h  = cfg_img_h;
    cfg_in.ker_w  = cfg_ker_w;
    cfg_in.ker_h  = cfg_ker_h;
    cfg_in.stride = cfg_stride;
    cfg_in.num_ch = cfg_num_ch;
    cfg_in.pad    = pad_in;
  end

  assign ext_w_in = EW'(cfg_in.img_w) + EW'({cfg_in.pad, 1'b0});
  assign ext_h_in = EW'(cfg_in.img_h) + EW'({cfg_in.pad, 1'b0});
  assign ext_w_q  = EW'(cfg_q.img_w)  + EW'({cfg_q.pad, 1'b0});
  assign ext_h_q  = EW'(cfg_q.img_h)  + EW'({cfg_q.pad, 1'b0});

  assign legal_in = (cfg_in.img_w != '0) && (cfg_in.img_h != '0) &&
                    (cfg_in.ker_w != '0) && (cfg_in.ker_h != '0) &&
                    (cfg_in.stride != '0) && (cfg_in.num_ch != '0) &&
                    (EW'(cfg_in.ker_w) <= ext_w_in) && (EW'(cfg_in.ker_h) <= ext_h_in);

  assign start_ok = (state == IDLE) && start;
  assign load     = start_ok && legal_in;
  assign fire     = addr_valid && addr_ready;
  // final beat: every loop level wraps on this accept
  assign fin      = &wrap;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = legal_in ? RUN : DONE;
      RUN:     if (fin)   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign conv_done = (state == DONE);

  // ---------------- loop counters ----------------
  always_comb begin
    step[0] = CW'(1);              lim[0] = CW'(cfg_q.ker_w) - CW'(1);
    step[1] = CW'(1);              lim[1] = CW'(cfg_q.ker_h) - CW'(1);
    step[2] = CW'(1);              lim[2] = CW'(cfg_q.num_ch) - CW'(1);
    step[3] = CW'(cfg_q.stride);   lim[3] = CW'(ext_w_q - EW'(cfg_q.ker_w));
    step[4] = CW'(cfg_q.stride);   lim[4] = CW'(ext_h_q - EW'(cfg_q.ker_h));
  end

  // level i advances when every inner level is on its last value
  always_comb begin
    en[0] = fire;
    for (int i = 1; i < NL; i++) en[i] = en[i-1] & at_last[i-1];
  end

  for (genvar i = 0; i < NL; i++) begin : g_cnt
    conv_addr_cnt #(.W(CW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (load),
      .en      (en[i]),
      .step    (step[i]),
      .limit   (lim[i]),
      .nxt     (nxt[i]),
      .at_last (at_last[i]),
      .wrap    (wrap[i])
    );
  end

  // ---------------- next-beat address ----------------
  // Outputs are registered from the counters' next values; on the start edge
  // the config inputs are used directly so beat 0 is valid one cycle later.
  assign w_n  = load ? cfg_in.img_w  : cfg_q.img_w;
  assign h_n  = load ? cfg_in.img_h  : cfg_q.img_h;
  assign kw_n = load ? cfg_in.ker_w  : cfg_q.ker_w;
  assign kh_n = load ? cfg_in.ker_h  : cfg_q.ker_h;
  assign c_n  = load ? cfg_in.num_ch : cfg_q.num_ch;

  assign wl_n = (nxt[0] == CW'(kw_n) - CW'(1)) &&
                (nxt[1] == CW'(kh_n) - CW'(1)) &&
                (nxt[2] == CW'(c_n)  - CW'(1));

`ifdef CONV_ADDR_PAD_EN
  assign p_n = load ? cfg_in.pad : cfg_q.pad;

  always_comb begin
    xs = $signed(SW'(nxt[3])) + $signed(SW'(nxt[0])) - $signed(SW'(p_n));
    ys = $signed(SW'(nxt[4])) + $signed(SW'(nxt[1])) - $signed(SW'(p_n));
    pad_n = (xs < 0) || (xs >= $signed(SW'(w_n))) ||
            (ys < 0) || (ys >= $signed(SW'(h_n)));
    a_full = '0;
    if (!pad_n)
      a_full = FW'(nxt[2]) * FW'(w_n) * FW'(h_n) +
               FW'($unsigned(ys)) * FW'(w_n) + FW'($unsigned(xs));
  end
`else
  assign a_full = FW'(nxt[2]) * FW'(w_n) * FW'(h_n) +
                  (FW'(nxt[4]) + FW'(nxt[1])) * FW'(w_n) +
                  FW'(nxt[3]) + FW'(nxt[0]);
`endif

  // ---------------- output / config registers ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cfg_q      <= '0;
      cfg_err    <= 1'b0;
      addr_valid <= 1'b0;
      addr       <= '0;
      win_last   <= 1'b0;
`ifdef CONV_ADDR_PAD_EN
      addr_pad   <= 1'b0;
`endif
    end else begin
      if (start_ok) begin
        cfg_q   <= cfg_in;
        cfg_err <= ~legal_in;
      end
      if (load)     addr_valid <= 1'b1;
      else if (fin) addr_valid <= 1'b0;
      if (fin) begin
        addr     <= '0;
        win_last <= 1'b0;
`ifdef CONV_ADDR_PAD_EN
        addr_pad <= 1'b0;
`endif
      end else if (load || fire) begin
        addr     <= a_full[ADDR_W-1:0];
        win_last <= wl_n;
`ifdef CONV_ADDR_PAD_EN
        addr_pad <= pad_n;
`endif
      end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
`timescale 1ns/1ps
module tb_conv_addr_gen;

  localparam int DIM_W  = 9;
  localparam int CH_W   = 4;
  localparam int ADDR_W = 18;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, addr_ready = 1'b0;
  logic [DIM_W-1:0] cfg_img_w = '0, cfg_img_h = '0, cfg_ker_w = '0, cfg_ker_h = '0, cfg_stride = '0;
  logic [CH_W-1:0]  cfg_num_ch = '0;
  logic [ADDR_W-1:0] addr;
  logic addr_valid, win_last, busy, conv_done, cfg_err;
`ifdef CONV_ADDR_PAD_EN
  logic [1:0] cfg_pad = '0;
  logic addr_pad;
`endif

  always #5 clk = ~clk;

  conv_addr_gen #(.DIM_W(DIM_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_ker_w(cfg_ker_w),
    .cfg_ker_h(cfg_ker_h), .cfg_stride(cfg_stride), .cfg_num_ch(cfg_num_ch),
`ifdef CONV_ADDR_PAD_EN
    .cfg_pad(cfg_pad), .addr_pad(addr_pad),
`endif
    .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .win_last(win_last), .busy(busy), .conv_done(conv_done), .cfg_err(cfg_err)
  );

  typedef struct {
    int w, h, kw, kh, s, c, p;
    int beats;   // expected beat count, -1 = take it from the model only
    bit err;
  } vec_t;

  typedef struct {
    int addr;
    bit wl;
    bit pad;
  } beat_t;

  vec_t  tbl[$];
  beat_t exp_q[$];
  int    got[$];
  bit    got_wl[$];
  bit    got_pad[$];
  int    n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic bit model_err(input vec_t v);
    return v.w == 0 || v.h == 0 || v.kw == 0 || v.kh == 0 || v.s == 0 || v.c == 0 ||
           v.kw > v.w + 2*v.p || v.kh > v.h + 2*v.p;
  endfunction

  // Reference: walk every window and every kernel tap in sweep order.
  function automatic void build_model(input vec_t v);
    exp_q.delete();
    if (model_err(v)) return;
    for (int oy = 0; oy + v.kh <= v.h + 2*v.p; oy += v.s)
      for (int ox = 0; ox + v.kw <= v.w + 2*v.p; ox += v.s)
        for (int ch = 0; ch < v.c; ch++)
          for (int ky = 0; ky < v.kh; ky++)
            for (int kx = 0; kx < v.kw; kx++) begin
              beat_t b;
              int x, y;
              x = ox + kx - v.p;
              y = oy + ky - v.p;
              b.pad  = (x < 0 || x >= v.w || y < 0 || y >= v.h);
              b.addr = b.pad ? 0 : (ch*v.w*v.h + y*v.w + x) % (1 << ADDR_W);
              b.wl   = (kx == v.kw-1 && ky == v.kh-1 && ch == v.c-1);
              exp_q.push_back(b);
            end
  endfunction

  task automatic drive_cfg(input vec_t v);
    cfg_img_w  = DIM_W'(v.w);
    cfg_img_h  = DIM_W'(v.h);
    cfg_ker_w  = DIM_W'(v.kw);
    cfg_ker_h  = DIM_W'(v.kh);
    cfg_stride = DIM_W'(v.s);
    cfg_num_ch = CH_W'(v.c);
`ifdef CONV_ADDR_PAD_EN
    cfg_pad    = 2'(v.p);
`endif
  endtask

  // mode 0: ready always 1; 1: random ready plus garbage cfg/start mid-run;
  // 2: ready dropped for 3 cycles while beat 5 is presented.
  // Entered and left at a sample point (#1 after a rising edge).
  task automatic run_cfg(input vec_t v, input int mode, input string nm);
    int cyc = 0, nacc = 0, last_acc = -1, done_cyc = -1, busy_n = 0, stall_n = 0;
    bit prev_stall = 0, err_seen = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic prev_wl = 1'b0;
    build_model(v);
    got.delete(); got_wl.delete(); got_pad.delete();
    drive_cfg(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!model_err(v)) chk({nm, " first_valid"}, addr_valid, 1);
    while (cyc < 4000) begin
      if (busy) busy_n++;
      if (conv_done) begin
        done_cyc = cyc;
        err_seen = cfg_err;
        break;
      end
      if (prev_stall)
        chk({nm, " hold"}, (addr_valid && addr == prev_addr && win_last == prev_wl), 1);
      case (mode)
        1:       addr_ready = 1'($urandom_range(0, 1));
        2:       if (nacc == 5 && stall_n < 3) begin addr_ready = 1'b0; stall_n++; end
                 else addr_ready = 1'b1;
        default: addr_ready = 1'b1;
      endcase
      if (addr_valid && addr_ready) begin
        if (nacc < exp_q.size()) begin
          chk($sformatf("%s addr[%0d]", nm, nacc), addr, exp_q[nacc].addr);
          chk($sformatf("%s win_last[%0d]", nm, nacc), win_last, exp_q[nacc].wl);
`ifdef CONV_ADDR_PAD_EN
          chk($sformatf("%s addr_pad[%0d]", nm, nacc), addr_pad, exp_q[nacc].pad);
          got_pad.push_back(addr_pad);
`endif
        end else chk({nm, " extra_beat"}, nacc, exp_q.size());
        got.push_back(int'(addr));
        got_wl.push_back(win_last);
        nacc++;
        last_acc = cyc;
      end
      prev_stall = addr_valid && !addr_ready;
      prev_addr  = addr;
      prev_wl    = win_last;
      if (mode == 1) begin
        cfg_img_w  = DIM_W'($urandom);
        cfg_ker_w  = DIM_W'($urandom);
        cfg_stride = DIM_W'($urandom);
        cfg_num_ch = CH_W'($urandom);
        start      = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    addr_ready = 1'b0;
    if (done_cyc < 0) chk({nm, " timeout"}, 0, 1);
    else begin
      chk({nm, " beats"}, nacc, exp_q.size());
      if (v.beats >= 0) chk({nm, " beats_tbl"}, nacc, v.beats);
      chk({nm, " cfg_err"}, err_seen, v.err);
      if (v.err) chk({nm, " done_at_t1"}, done_cyc, 0);
      else       chk({nm, " done_timing"}, done_cyc, last_acc + 1);
      if (mode == 0) chk({nm, " busy_cycles"}, busy_n, exp_q.size() + 1);
    end
    @(posedge clk); #1;
    chk({nm, " idle"}, {busy, conv_done, addr_valid}, 0);
    chk({nm, " err_sticky"}, cfg_err, v.err);
  endtask

  initial begin
    int exp_a[8];
    int exp_b[4];
    vec_t r;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst addr", addr, 0);
    chk("rst flags", {addr_valid, win_last, busy, conv_done, cfg_err}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    //                w  h kw kh  s  c  p beats err
    tbl.push_back('{4, 4, 2, 2, 1, 1, 0, 36, 0});
    tbl.push_back('{4, 4, 2, 2, 2, 1, 0, 16, 0});
    tbl.push_back('{3, 3, 2, 2, 1, 2, 0, 32, 0});
    tbl.push_back('{4, 4, 2, 2, 0, 1, 0,  0, 1});
    tbl.push_back('{4, 4, 5, 2, 1, 1, 0,  0, 1});
    tbl.push_back('{4, 4, 2, 2, 1, 0, 0,  0, 1});
    tbl.push_back('{0, 4, 1, 1, 1, 1, 0,  0, 1});
    tbl.push_back('{5, 3, 3, 1, 2, 3, 0, 36, 0});
    tbl.push_back('{2, 2, 1, 1, 1, 1, 0,  4, 0});
    tbl.push_back('{3, 2, 3, 2, 3, 1, 0,  6, 0});
`ifdef CONV_ADDR_PAD_EN
    tbl.push_back('{3, 3, 3, 3, 1, 1, 1, 81, 0});
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      run_cfg(tbl[i], 0, $sformatf("tbl%0d", i));
      if (i == 0) begin
        exp_a = '{0, 1, 4, 5, 1, 2, 5, 6};
        exp_b = '{10, 11, 14, 15};
        for (int k = 0; k < 8; k++) chk($sformatf("s1 first[%0d]", k), got[k], exp_a[k]);
        for (int k = 0; k < 4; k++) chk($sformatf("s1 last[%0d]", k), got[32+k], exp_b[k]);
        begin
          int bad = 0;
          for (int k = 0; k < got_wl.size(); k++) if (got_wl[k] != ((k % 4) == 3)) bad++;
          chk("s1 wl_every4", bad, 0);
        end
      end
      if (i == 1) begin
        exp_b = '{0, 2, 8, 10};
        for (int k = 0; k < 4; k++) chk($sformatf("s2 origin[%0d]", k), got[4*k], exp_b[k]);
      end
      if (i == 2) begin
        exp_a = '{0, 1, 3, 4, 9, 10, 12, 13};
        for (int k = 0; k < 8; k++) chk($sformatf("c2 win0[%0d]", k), got[k], exp_a[k]);
        chk("c2 wl_beat8", {got_wl[7], got_wl[6], got_wl[0]}, 3'b100);
      end
`ifdef CONV_ADDR_PAD_EN
      if (tbl[i].p == 1) begin
        chk("pad beat0", {got_pad[0], 18'(got[0])}, {1'b1, 18'd0});
        chk("pad beat4", {got_pad[4], 18'(got[4])}, {1'b0, 18'd0});
      end
`endif
    end

    // reset in the middle of a run
    drive_cfg(tbl[0]);
    start = 1'b1; addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst pre_valid", addr_valid, 1);
    chk("midrst pre_addr", addr, 3);
    reset = 1'b1;
    #1;
    chk("midrst addr", addr, 0);
    chk("midrst flags", {addr_valid, win_last, busy, conv_done, cfg_err}, 0);
    #1 reset = 1'b0;
    addr_ready = 1'b0;
    @(posedge clk); #1;
    chk("midrst idle", {addr_valid, busy}, 0);
    run_cfg(tbl[0], 0, "post_rst");
    chk("post_rst addr0", got[0], 0);

    // backpressure at beat 5
    run_cfg(tbl[0], 2, "bp");
    run_cfg(tbl[2], 2, "bp_c2");

    // randomized configs, random ready, noisy cfg/start while busy
    for (int i = 0; i < 12; i++) begin
      r.w  = $urandom_range(1, 6);
      r.h  = $urandom_range(1, 6);
      r.kw = $urandom_range(1, r.w + 1);
      r.kh = $urandom_range(1, r.h + 1);
      r.s  = (i % 5 == 4) ? 0 : $urandom_range(1, 3);
      r.c  = $urandom_range(1, 3);
`ifdef CONV_ADDR_PAD_EN
      r.p  = $urandom_range(0, 1);
`else
      r.p  = 0;
`endif
      r.beats = -1;
      r.err   = model_err(r);
      run_cfg(r, 1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
